ntlm_md4_driver: RTL and testbench
==================================

Name: ntlm_md4_driver

Overview:
- Producer/consumer for the md4block compute unit.
- Takes an ASCII password as a byte stream, builds the single padded 512-bit NT-hash message block (UTF-16LE expansion, 0x80 terminator, 64-bit bit length), starts md4block, captures its new state, and returns a 128-bit NT digest plus a match flag against a target hash.
- One instance sits beside each md4block in a cracking lane.

Parameters:
- MAX_CHARS, 27, longest accepted password in characters; must be 1..27 so 2*n+9 <= 64 bytes fits one block.
- MD4_LATENCY, 54, md4block cycles from start to idle; sizes the post-reset guard counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  password byte valid.
- in_ready  out  1  driver accepts byte; transfer when in_valid & in_ready.
- in_byte  in  8  ASCII character.
- in_last  in  1  marks final character of the password.
- target_hash  in  128  reference NT digest, byte 0 in bits 127:120; sampled when out_valid rises.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out_digest  out  128  NT digest, byte 0 in bits 127:120.
- out_match  out  1  out_digest == target_hash.
- out_err  out  1  password exceeded MAX_CHARS; digest forced to 0.
- md4_irdy  out  1  start pulse to md4block.
- md4_state_a/b/c/d  out  32 each  initial chaining value, constant 67452301/EFCDAB89/98BADCFE/10325476.
- md4_data  out  512  message block, message byte 0 in bits 511:504.
- md4_ordy  in  1  md4block result strobe (high 2 cycles).
- md4_newstate_a/b/c/d  in  32 each  md4block result, valid while md4_ordy=1.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_digest=0, out_match=0, out_err=0, md4_irdy=0, md4_data=0. Char counter=0. State GUARD. Guard counter loaded with MD4_LATENCY.
- GUARD: decrement each cycle. At 0 go to COLLECT. This guarantees a md4block left running across a driver reset has returned idle. md4_ordy is ignored in GUARD (it may be X at power-up).
- COLLECT: in_ready=1. Each accepted byte at count n:
  - md4_data byte 2n = char, byte 2n+1 = 0x00.
  - n increments.
  - If n reaches MAX_CHARS without in_last, set err and go to DRAIN.
  - Accepted byte with in_last: go to FINALIZE. md4_data was cleared on entry to COLLECT.
- DRAIN: in_ready=1, discard bytes. On in_last go to RESULT with out_err=1, out_digest=0, out_match=0. No md4 run.
- FINALIZE (1 cycle): byte 2n=0x80; bytes 56..63 = 16n as 64-bit little-endian (byte56 = low 8 bits). Go to START.
- START (1 cycle): md4_irdy=1. md4_irdy is never high in any other state. Go to WAIT.
- WAIT: md4_data and md4_state_* held stable.
  - On the first cycle with md4_ordy=1, capture digest = {bswap32(A_new), bswap32(B_new), bswap32(C_new), bswap32(D_new)}.
  - Go to RESULT; out_match is computed next cycle from the registered digest.
- RESULT: out_valid=1, outputs stable.
  - Leave when out_ready=1 AND md4_ordy=0, so md4block is idle before any restart.
  - Then clear out_valid, out_err and md4_data, zero n, and enter COLLECT.
- Latency: last byte accepted at cycle T gives FINALIZE at T+1, md4_irdy at T+2, md4_ordy at about T+2+51, out_valid 2 cycles after md4_ordy is first seen.
- Simultaneous in_last and overflow at n=MAX_CHARS: valid, not an error (exactly MAX_CHARS chars).
- Reset mid-operation: all state cleared asynchronously; GUARD is re-entered; an in-flight md4 result is discarded.

Decomposition:
- Shared package ntlm_pkg holds:
  - MD4 IV constants;
  - MAX_CHARS upper limit 27;
  - state enum {GUARD, COLLECT, DRAIN, FINALIZE, START, WAIT, RESULT};
  - bswap32 from the common byteswap include.
- One natural sub-module: ntlm_block_builder, which owns the 512-bit block register, byte-lane writes, terminator and length insertion.

Test Plan:
- "password" (8 bytes, last on 'd') -> one md4_irdy pulse; out_digest=8846F7EAEE8FB117AD06BDD830B7586C; out_match=1 with that target, 0 with target all-zero.
- "a" -> md4_data bytes 0..2 = 61 00 80, byte56=0x10, all others 0 at md4_irdy.
- 27-char string -> byte54=0x80, byte55=0, byte56=0xB0, byte57=0x01, rest 0; out_err=0.
- 28-char string -> no md4_irdy; out_valid with out_err=1, digest 0; the next password hashes correctly.
- out_ready held low 100 cycles -> outputs stable, in_ready=0, no second md4_irdy.
- Assert rst_n low 10 cycles into WAIT -> outputs at reset values; in_ready stays 0 for MD4_LATENCY cycles; the next "password" yields the correct digest.

Source files
------------

// File: rtl/ntlm_pkg.sv
// Shared types and constants for the NT-hash driver lane.
// MD4 chaining IV, state encoding and byte-order helper.
package ntlm_pkg;

  localparam logic [31:0] MD4_IV_A = 32'h67452301;
  localparam logic [31:0] MD4_IV_B = 32'hEFCDAB89;
  localparam logic [31:0] MD4_IV_C = 32'h98BADCFE;
  localparam logic [31:0] MD4_IV_D = 32'h10325476;

  localparam int MAX_CHARS_LIMIT = 27;

  typedef enum logic [2:0] {
    GUARD,
    COLLECT,
    DRAIN,
    FINALIZE,
    START,
    WAIT,
    RESULT
  } state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/ntlm_block_builder.sv
// Owns the 512-bit MD4 message block: UTF-16LE lanes,
// 0x80 terminator and the little-endian bit length.
module ntlm_block_builder
  import ntlm_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         wr_i,
  input  logic [4:0]   idx_i,
  input  logic [7:0]   char_i,
  input  logic         fin_i,
  input  logic [4:0]   n_i,
  output logic [511:0] data_o
);

  logic [511:0] blk_q;
  logic [511:0] blk_d;
  logic [9:0]   wr_msb;
  logic [9:0]   fin_msb;

  // Byte k of the block lives at bits 511-8k downto 504-8k.
  assign wr_msb  = 10'd511 - {1'b0, idx_i, 4'b0};
  assign fin_msb = 10'd511 - {1'b0, n_i, 4'b0};

  // Next block: clear, character lane write, or terminator + length.
  always_comb begin
    blk_d = blk_q;
    if (clr_i) begin
      blk_d = '0;
    end else if (wr_i) begin
      blk_d[wr_msb -: 8]         = char_i;
      blk_d[wr_msb - 10'd8 -: 8] = 8'h00;
    end else if (fin_i) begin
      blk_d[fin_msb -: 8] = 8'h80;
      blk_d[63:56]        = {n_i[3:0], 4'h0};
      blk_d[55:48]        = {7'd0, n_i[4]};
    end
  end

  // Block register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blk_q <= '0;
    else        blk_q <= blk_d;
  end

  assign data_o = blk_q;

endmodule

// File: rtl/ntlm_md4_driver.sv
// NT-hash lane driver: collects a password, runs one
// md4block pass and returns the digest plus a match flag.
module ntlm_md4_driver
  import ntlm_pkg::*;
#(
  parameter int MAX_CHARS   = 27,
  parameter int MD4_LATENCY = 54
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_last,
  input  logic [127:0] target_hash,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_digest,
  output logic         out_match,
  output logic         out_err,
  output logic         md4_irdy,
  output logic [31:0]  md4_state_a,
  output logic [31:0]  md4_state_b,
  output logic [31:0]  md4_state_c,
  output logic [31:0]  md4_state_d,
  output logic [511:0] md4_data,
  input  logic         md4_ordy,
  input  logic [31:0]  md4_newstate_a,
  input  logic [31:0]  md4_newstate_b,
  input  logic [31:0]  md4_newstate_c,
  input  logic [31:0]  md4_newstate_d
);

  localparam int GW = $clog2(MD4_LATENCY + 1);

  state_e         state_q, state_d;
  logic [GW-1:0]  guard_q, guard_d;
  logic [4:0]     n_q, n_d;
  logic           err_q, err_d;
  logic [127:0]   dig_q, dig_d;
  logic           match_q, match_d;
  logic           oval_q, oval_d;
  logic           clr, wr, fin;
  logic           in_fire;
  logic [5:0]     n_nxt;

  assign in_ready = (state_q == COLLECT) || (state_q == DRAIN);
  assign md4_irdy = (state_q == START);
  assign in_fire  = in_valid && in_ready;
  assign n_nxt    = {1'b0, n_q} + 6'd1;

  // Next-state and datapath control for the lane FSM.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    n_d     = n_q;
    err_d   = err_q;
    dig_d   = dig_q;
    match_d = match_q;
    oval_d  = oval_q;
    clr     = 1'b0;
    wr      = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      GUARD: begin
        if (guard_q == '0) begin
          state_d = COLLECT;
          clr     = 1'b1;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      COLLECT: begin
        if (in_fire) begin
          wr  = 1'b1;
          n_d = n_nxt[4:0];
          if (in_last) begin
            state_d = FINALIZE;
          end else if (n_nxt == 6'(MAX_CHARS)) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (in_fire && in_last) begin
          dig_d   = '0;
          state_d = RESULT;
        end
      end
      FINALIZE: begin
        fin     = 1'b1;
        state_d = START;
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (md4_ordy) begin
          dig_d = {bswap32(md4_newstate_a),
                   bswap32(md4_newstate_b),
                   bswap32(md4_newstate_c),
                   bswap32(md4_newstate_d)};
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (!oval_q) begin
          oval_d  = 1'b1;
          match_d = !err_q && (dig_q == target_hash);
        end else if (out_ready && !md4_ordy) begin
          oval_d  = 1'b0;
          err_d   = 1'b0;
          n_d     = '0;
          clr     = 1'b1;
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = GUARD;
      end
    endcase
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GUARD;
      guard_q <= GW'(MD4_LATENCY);
      n_q     <= '0;
      err_q   <= 1'b0;
      dig_q   <= '0;
      match_q <= 1'b0;
      oval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      n_q     <= n_d;
      err_q   <= err_d;
      dig_q   <= dig_d;
      match_q <= match_d;
      oval_q  <= oval_d;
    end
  end

  ntlm_block_builder u_blk (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .wr_i   (wr),
    .idx_i  (n_q),
    .char_i (in_byte),
    .fin_i  (fin),
    .n_i    (n_q),
    .data_o (md4_data)
  );

  assign out_valid   = oval_q;
  assign out_digest  = dig_q;
  assign out_match   = match_q;
  assign out_err     = err_q;
  assign md4_state_a = MD4_IV_A;
  assign md4_state_b = MD4_IV_B;
  assign md4_state_c = MD4_IV_C;
  assign md4_state_d = MD4_IV_D;

endmodule

// File: tb/tb_ntlm_md4_driver.sv
// Bench for ntlm_md4_driver: behavioural md4block stand-in
// plus a byte-level NT-hash reference model.
module tb_ntlm_md4_driver;

  localparam int MAXC = 27;
  localparam int LAT  = 54;
  localparam logic [127:0] PW_HASH =
    128'h8846F7EAEE8FB117AD06BDD830B7586C;

  typedef logic [7:0] bq_t [$];

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_byte = 8'h00;
  logic         in_last = 1'b0;
  logic [127:0] target_hash = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_digest;
  logic         out_match;
  logic         out_err;
  logic         md4_irdy;
  logic [31:0]  md4_state_a, md4_state_b;
  logic [31:0]  md4_state_c, md4_state_d;
  logic [511:0] md4_data;
  logic         md4_ordy = 1'b0;
  logic [31:0]  nsa = '0, nsb = '0, nsc = '0, nsd = '0;

  int checks = 0;
  int failures = 0;
  int irdy_cnt = 0;
  logic [511:0] cap_data = '0;

  always #5 clk = ~clk;

  ntlm_md4_driver #(.MAX_CHARS(MAXC), .MD4_LATENCY(LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_byte        (in_byte),
    .in_last        (in_last),
    .target_hash    (target_hash),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_digest     (out_digest),
    .out_match      (out_match),
    .out_err        (out_err),
    .md4_irdy       (md4_irdy),
    .md4_state_a    (md4_state_a),
    .md4_state_b    (md4_state_b),
    .md4_state_c    (md4_state_c),
    .md4_state_d    (md4_state_d),
    .md4_data       (md4_data),
    .md4_ordy       (md4_ordy),
    .md4_newstate_a (nsa),
    .md4_newstate_b (nsb),
    .md4_newstate_c (nsc),
    .md4_newstate_d (nsd)
  );

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x,
                                      input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] bsw(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic int shamt(input int r, input int m);
    int t1 [4] = '{3, 7, 11, 19};
    int t2 [4] = '{3, 5, 9, 13};
    int t3 [4] = '{3, 9, 11, 15};
    if (r == 0) return t1[m];
    if (r == 1) return t2[m];
    return t3[m];
  endfunction

  // RFC 1320 compression of one block from the standard IV.
  function automatic logic [127:0] md4_core(input logic [511:0] blk);
    logic [31:0] x [16];
    logic [31:0] v [4];
    logic [31:0] b, c, d, f, kc;
    int t, kk;
    for (int i = 0; i < 16; i++)
      x[i] = {blk[511-8*(4*i+3) -: 8], blk[511-8*(4*i+2) -: 8],
              blk[511-8*(4*i+1) -: 8], blk[511-8*(4*i) -: 8]};
    v[0] = 32'h67452301; v[1] = 32'hEFCDAB89;
    v[2] = 32'h98BADCFE; v[3] = 32'h10325476;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 16; j++) begin
        t = (4 - (j % 4)) % 4;
        b = v[(t+1)%4]; c = v[(t+2)%4]; d = v[(t+3)%4];
        if (r == 0) begin
          f = (b & c) | (~b & d); kk = j; kc = 32'h0;
        end else if (r == 1) begin
          f = (b & c) | (b & d) | (c & d);
          kk = (j % 4) * 4 + j / 4; kc = 32'h5A827999;
        end else begin
          f = b ^ c ^ d;
          kk = ((j & 1) << 3) | ((j & 2) << 1) |
               ((j & 4) >> 1) | ((j & 8) >> 3);
          kc = 32'h6ED9EBA1;
        end
        v[t] = rol(v[t] + f + x[kk] + kc, shamt(r, j % 4));
      end
    end
    return {v[0] + 32'h67452301, v[1] + 32'hEFCDAB89,
            v[2] + 32'h98BADCFE, v[3] + 32'h10325476};
  endfunction

  function automatic logic [511:0] build_block(input bq_t pw);
    logic [7:0] bt [64];
    logic [63:0] len;
    logic [511:0] r;
    int n;
    n = pw.size();
    for (int i = 0; i < 64; i++) bt[i] = 8'h00;
    for (int i = 0; i < n; i++) bt[2*i] = pw[i];
    bt[2*n] = 8'h80;
    len = 64'(16 * n);
    for (int i = 0; i < 8; i++) bt[56+i] = len[8*i +: 8];
    for (int i = 0; i < 64; i++) r[511-8*i -: 8] = bt[i];
    return r;
  endfunction

  function automatic logic [127:0] nt_digest(input logic [511:0] blk);
    logic [127:0] s;
    s = md4_core(blk);
    return {bsw(s[127:96]), bsw(s[95:64]), bsw(s[63:32]), bsw(s[31:0])};
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t rand_pw(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(32, 126)));
    return q;
  endfunction

  // Start pulse / data snapshot monitor.
  always @(negedge clk) begin
    if (md4_irdy === 1'b1) begin
      irdy_cnt++;
      cap_data = md4_data;
    end
  end

  // md4block stand-in: result strobe ~51 cycles after start, 2 cycles wide.
  initial begin
    logic [511:0] blk_m;
    forever begin
      @(negedge clk);
      if (md4_irdy === 1'b1) begin
        blk_m = md4_data;
        repeat (50) @(posedge clk);
        #1;
        {nsa, nsb, nsc, nsd} = md4_core(blk_m);
        md4_ordy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        md4_ordy = 1'b0;
        nsa = $urandom; nsb = $urandom;
        nsc = $urandom; nsd = $urandom;
      end
    end
  end

  task automatic send_pw(input bq_t pw);
    int cyc;
    bit ok;
    for (int i = 0; i < pw.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_byte  = pw[i];
      in_last  = (i == pw.size() - 1);
      cyc = 0;
      ok  = 1'b0;
      while (!ok && cyc < 300) begin
        @(negedge clk);
        if (in_ready) ok = 1'b1;
        cyc++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!ok) begin
        chk("in_ready_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic wait_result();
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 400);
    chk("out_valid_timeout", out_valid, 1);
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_case(input string tag, input bq_t pw,
                          input bit use_match, input int hold);
    bit err;
    logic [511:0] blk;
    logic [127:0] dig, snap;
    int i0, diffs, rdy;
    err = pw.size() > MAXC;
    blk = '0;
    dig = '0;
    if (!err) begin
      blk = build_block(pw);
      dig = nt_digest(blk);
    end
    if (use_match && !err) target_hash = dig;
    else target_hash = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    i0 = irdy_cnt;
    send_pw(pw);
    wait_result();
    chk({tag, "_err"}, out_err, err);
    chk({tag, "_dig"}, out_digest, dig);
    chk({tag, "_match"}, out_match, use_match && !err);
    chk({tag, "_starts"}, irdy_cnt - i0, err ? 0 : 1);
    if (!err) chk({tag, "_data"}, cap_data, blk);
    if (hold > 0) begin
      snap = out_digest;
      diffs = 0;
      rdy = 0;
      repeat (hold) begin
        @(negedge clk);
        if (!out_valid || out_digest !== snap) diffs++;
        if (out_match !== (use_match && !err)) diffs++;
        if (in_ready) rdy++;
      end
      chk({tag, "_hold_stable"}, diffs, 0);
      chk({tag, "_hold_ready"}, rdy, 0);
      chk({tag, "_hold_starts"}, irdy_cnt - i0, 1);
    end
    accept();
  endtask

  task automatic guard_check(input string tag);
    int rdy = 0;
    repeat (LAT) begin
      @(negedge clk);
      if (in_ready) rdy++;
    end
    chk(tag, rdy, 0);
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    chk({tag, "_ctl"},
        {in_ready, out_valid, out_match, out_err, md4_irdy}, 5'b0);
    chk({tag, "_dig"}, out_digest, 0);
    chk({tag, "_data"}, md4_data, 0);
  endtask

  initial begin
    bq_t pw;
    int i0, cyc;
    #2 rst_n = 1'b0;
    reset_check("rst");
    chk("iv", {md4_state_a, md4_state_b, md4_state_c, md4_state_d},
        128'h67452301EFCDAB8998BADCFE10325476);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    guard_check("guard_ready");

    pw = str2q("password");
    run_case("pw", pw, 1'b1, 0);
    chk("pw_known", out_digest, PW_HASH);

    target_hash = '0;
    send_pw(pw);
    wait_result();
    chk("pw_t0_match", out_match, 0);
    chk("pw_t0_dig", out_digest, PW_HASH);
    accept();

    run_case("a", str2q("a"), 1'b1, 0);
    chk("a_b012", cap_data[511:488], 24'h610080);
    chk("a_b56", cap_data[63:56], 8'h10);

    run_case("max", rand_pw(MAXC), 1'b1, 0);
    chk("max_tail", cap_data[79:48], 32'h8000B001);

    run_case("ovf28", rand_pw(MAXC + 1), 1'b0, 0);
    run_case("ovf31", rand_pw(MAXC + 4), 1'b0, 0);
    run_case("after_ovf", rand_pw(5), 1'b1, 0);

    run_case("hold", rand_pw(9), 1'b1, 100);

    for (int k = 0; k < 8; k++)
      run_case($sformatf("rnd%0d", k), rand_pw($urandom_range(1, 30)),
               1'($urandom_range(0, 1)), 0);

    target_hash = PW_HASH;
    i0 = irdy_cnt;
    send_pw(pw);
    cyc = 0;
    while (irdy_cnt == i0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_start_seen", irdy_cnt - i0, 1);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    reset_check("mid_rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    guard_check("mid_guard_ready");
    chk("mid_out_valid", out_valid, 0);
    run_case("post_rst", pw, 1'b1, 0);
    chk("post_rst_known", out_digest, PW_HASH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
